tl45_register_read: RTL

//  Operand-fetch stage feeding the execute stage; drives the buffer the ALU consumes
//  (opcode, dr, jmp_cond, sr1/sr2 values, target offset, pc).

---
 rtl/tl45_register_read.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/tl45_register_read.sv
// rtl/tl45_register_read.sv - operand fetch: rf read, forwarding, imm mux, load-use bubble, stall/flush buffer
// Optional cycle/bubble performance counters are enabled by defining TL45_RR_PERF_EN.
module tl45_register_read #(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_pipe_stall,
    input  logic          i_pipe_flush,
    output logic          o_pipe_stall,
    output logic          o_pipe_flush,
    input  logic [4:0]    i_opcode,
    input  logic [RW-1:0] i_dr,
    input  logic [RW-1:0] i_sr1,
    input  logic [RW-1:0] i_sr2,
    input  logic [DW-1:0] i_imm,
    input  logic          i_imm_valid,
    input  logic [3:0]    i_jmp_cond,
    input  logic [DW-1:0] i_target_offset,
    input  logic [DW-1:0] i_pc,
    output logic [RW-1:0] o_rf_sr1,
    output logic [RW-1:0] o_rf_sr2,
    input  logic [DW-1:0] i_rf_sr1_val,
    input  logic [DW-1:0] i_rf_sr2_val,
    input  logic [RW-1:0] i_of1_reg,
    input  logic [DW-1:0] i_of1_val,
    input  logic [RW-1:0] i_of2_reg,
    input  logic [DW-1:0] i_of2_val,
    input  logic          i_ld_pending,
    input  logic [RW-1:0] i_ld_dr,
`ifdef TL45_RR_PERF_EN
    output logic [DW-1:0] o_perf_stall,
    output logic [DW-1:0] o_perf_bubble,
`endif
    output logic [4:0]    o_opcode,
    output logic [RW-1:0] o_dr,
    output logic [3:0]    o_jmp_cond,
    output logic [DW-1:0] o_sr1_val,
    output logic [DW-1:0] o_sr2_val,
    output logic [DW-1:0] o_target_offset,
    output logic [DW-1:0] o_pc
);

    // Newest forward (execute) wins; a forward tagged r0 is treated as absent.
    function automatic logic [DW-1:0] resolve(
        input logic [RW-1:0] a,
        input logic [DW-1:0] rf_val,
        input logic [RW-1:0] of1_reg,
        input logic [DW-1:0] of1_val,
        input logic [RW-1:0] of2_reg,
        input logic [DW-1:0] of2_val
    );
        if (a == '0)
            return '0;
        else if (a == of1_reg)
            return of1_val;
        else if (a == of2_reg)
            return of2_val;
        else
            return rf_val;
    endfunction

    logic [DW-1:0] sr1_res;
    logic [DW-1:0] sr2_res;
    logic          hazard;

    assign o_rf_sr1 = i_sr1;
    assign o_rf_sr2 = i_sr2;

    assign sr1_res = resolve(i_sr1, i_rf_sr1_val, i_of1_reg, i_of1_val, i_of2_reg, i_of2_val);
    assign sr2_res = i_imm_valid ? i_imm
                   : resolve(i_sr2, i_rf_sr2_val, i_of1_reg, i_of1_val, i_of2_reg, i_of2_val);

    assign hazard = i_ld_pending && (i_ld_dr != '0) && (i_opcode != 5'd0) &&
                    ((i_sr1 == i_ld_dr) || (!i_imm_valid && (i_sr2 == i_ld_dr)));

    assign o_pipe_stall = i_pipe_stall | hazard;
    assign o_pipe_flush = i_pipe_flush;

    logic [4:0]    opcode_q,        opcode_d;
    logic [RW-1:0] dr_q,            dr_d;
    logic [3:0]    jmp_cond_q,      jmp_cond_d;
    logic [DW-1:0] sr1_val_q,       sr1_val_d;
    logic [DW-1:0] sr2_val_q,       sr2_val_d;
    logic [DW-1:0] target_offset_q, target_offset_d;
    logic [DW-1:0] pc_q,            pc_d;

    // Flush beats stall; a stall holds the already-resolved operands untouched.
    always_comb begin
        opcode_d        = opcode_q;
        dr_d            = dr_q;
        jmp_cond_d      = jmp_cond_q;
        sr1_val_d       = sr1_val_q;
        sr2_val_d       = sr2_val_q;
        target_offset_d = target_offset_q;
        pc_d            = pc_q;
        if (i_pipe_flush || (!i_pipe_stall && hazard)) begin
            opcode_d        = '0;
            dr_d            = '0;
            jmp_cond_d      = '0;
            sr1_val_d       = '0;
            sr2_val_d       = '0;
            target_offset_d = '0;
            pc_d            = '0;
        end else if (!i_pipe_stall) begin
            opcode_d        = i_opcode;
            dr_d            = i_dr;
            jmp_cond_d      = i_jmp_cond;
            sr1_val_d       = sr1_res;
            sr2_val_d       = sr2_res;
            target_offset_d = i_target_offset;
            pc_d            = i_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            opcode_q        <= '0;
            dr_q            <= '0;
            jmp_cond_q      <= '0;
            sr1_val_q       <= '0;
            sr2_val_q       <= '0;
            target_offset_q <= '0;
            pc_q            <= '0;
        end else begin
            opcode_q        <= opcode_d;
            dr_q            <= dr_d;
            jmp_cond_q      <= jmp_cond_d;
            sr1_val_q       <= sr1_val_d;
            sr2_val_q       <= sr2_val_d;
            target_offset_q <= target_offset_d;
            pc_q            <= pc_d;
        end
    end

    assign o_opcode        = opcode_q;
    assign o_dr            = dr_q;
    assign o_jmp_cond      = jmp_cond_q;
    assign o_sr1_val       = sr1_val_q;
    assign o_sr2_val       = sr2_val_q;
    assign o_target_offset = target_offset_q;
    assign o_pc            = pc_q;

`ifdef TL45_RR_PERF_EN
    logic [DW-1:0] perf_stall_q,  perf_stall_d;
    logic [DW-1:0] perf_bubble_q, perf_bubble_d;

    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_bubble_d = perf_bubble_q;
        if (i_pipe_stall && (perf_stall_q != '1))
            perf_stall_d = perf_stall_q + 1'b1;
        if (hazard && !i_pipe_stall && !i_pipe_flush && (perf_bubble_q != '1))
            perf_bubble_d = perf_bubble_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign o_perf_stall  = perf_stall_q;
    assign o_perf_bubble = perf_bubble_q;
`endif

endmodule
